ibex_data_resp: RTL and testbench
=================================

IBEX_DATA_RESP -- requirements
Module: ibex_data_resp

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clock port is clk_i, reset port is rst_ni.
REQ-002 Parameter BaseAddr SHALL default to 32'h0001_0000 and set the 64-byte-aligned region base.
REQ-003 Parameter Latency SHALL default to 1, allowed range 1..7, and set the cycles from grant to rvalid.
REQ-004 clk_i  input  1  rising-edge clock.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 data_req_i  input  1  request from Ibex LSU.
REQ-007 data_gnt_o  output  1  request accepted this cycle.
REQ-008 data_rvalid_o  output  1  response valid; one-cycle pulse.
REQ-009 data_we_i  input  1  1 = write, 0 = read.
REQ-010 data_be_i  input  4  byte enables; bit n covers wdata[8n+7:8n].
REQ-011 data_addr_i  input  32  byte address; bits [1:0] ignored.
REQ-012 data_wdata_i  input  32  write data.
REQ-013 data_rdata_o  output  32  read data; valid only with rvalid.
REQ-014 data_err_o  output  1  error flag; valid only with rvalid.

Function
REQ-015 Storage SHALL be 15 read/write 32-bit words at indices 0..14 (index = addr[5:2]); index 15 SHALL be a read-only free-running 32-bit cycle counter.
REQ-016 An access SHALL be in range iff addr[31:6] == BaseAddr[31:6].
REQ-017 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-018 data_gnt_o SHALL be 1 in IDLE and 0 in WAIT and RESP.
REQ-019 Handshake: req_i && gnt_o at a rising edge SHALL capture the request.
- Latency == 1: IDLE -> RESP.
- Latency > 1: IDLE -> WAIT with a down-counter loaded with Latency-2.
REQ-020 WAIT SHALL decrement the counter each cycle and go to RESP when it is 0.
REQ-021 RESP SHALL assert data_rvalid_o for exactly one cycle, then go to IDLE.
- Grant-to-rvalid distance SHALL be exactly Latency cycles.
- Minimum request spacing SHALL be Latency+1 cycles.
REQ-022 An in-range write to index 0..14 SHALL update only the bytes whose be bit is 1, at the handshake edge; be == 4'b0000 SHALL be a legal no-op write with err=0.
REQ-023 Read data SHALL be sampled at the handshake edge.
- Counter reads SHALL return the counter value during the grant cycle.
REQ-024 A write to index 15 SHALL leave the counter unchanged and respond with err=1.
REQ-025 An out-of-range access SHALL change no state and respond with err=1, rdata=0.
REQ-026 data_rdata_o SHALL be 0 for write responses and whenever data_rvalid_o is 0.
REQ-027 data_err_o SHALL be 0 whenever data_rvalid_o is 0.
REQ-028 Input changes while gnt_o is 0 SHALL be ignored; Ibex holds req/addr until granted.
REQ-029 The cycle counter SHALL increment every cycle and wrap from 32'hFFFF_FFFF to 0.
REQ-030 Latency values outside 1..7 SHALL fail an elaboration-time assertion.

Reset
REQ-031 While rst_ni is 0, outputs SHALL be: gnt=0, rvalid=0, rdata=0, err=0; state IDLE, storage 0, counter 0.
REQ-032 Reset asserted in WAIT or RESP SHALL drop the pending response; no rvalid SHALL be produced for it after reset deasserts.
REQ-033 data_gnt_o SHALL rise in the first cycle after rst_ni deasserts.

Verification
REQ-034 Latency=1: write 0x1234_5678, be=4'hF to BaseAddr+0x08, then read it -> gnt in the request cycle, rvalid the next cycle, read rdata=0x1234_5678, err=0.
REQ-035 Byte-enable merge: write 0xAABB_CCDD be=4'hF, then 0x1122_3344 be=4'b0101, to index 3 -> read returns 0xAA22_CC44.
REQ-036 Read BaseAddr+0x40 and write BaseAddr-4 -> err=1, rdata=0, all 15 words unchanged.
REQ-037 Latency=4: back-to-back requests -> rvalid exactly 4 cycles after each grant; gnt low for cycles 1..4 after each grant.
REQ-038 Counter: read index 15 granted at cycle N after reset -> rdata=N; write to index 15 -> err=1 and counter unchanged.
REQ-039 Reset in WAIT (Latency=3) -> no rvalid after reset; subsequent read of index 0 returns 0.

Source files
------------

// File: rtl/ibex_data_resp.sv
// Ibex data-port slave: 15 byte-writable words plus a read-only cycle counter,
// answering each granted request after a fixed, parameterised latency.
module ibex_data_resp #(
   parameter logic [31:0] BaseAddr = 32'h0001_0000,
   parameter int unsigned Latency  = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o
);

   localparam int unsigned NumWords = 15;
   localparam int unsigned IdxW     = 4;
   localparam int unsigned WaitW    = 3;
   localparam int unsigned DataW    = 32;
   localparam int unsigned NumBytes = 4;

   if (Latency < 1 || Latency > 7) begin : g_bad_latency
      $error("ibex_data_resp: Latency must be within 1..7");
   end

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   state_e             state;
   logic [WaitW-1:0]   wait_cnt;
   logic [DataW-1:0]   mem [NumWords];
   logic [DataW-1:0]   cycle_cnt;
   logic [DataW-1:0]   resp_rdata;
   logic               resp_err;

   logic [IdxW-1:0]    idx;
   logic               in_range;
   logic               handshake;
   logic               mem_we;
   logic [DataW-1:0]   rd_val;
   logic               rd_err;
   logic               unused_addr_bits;

   assign idx              = data_addr_i[5:2];
   assign in_range         = (data_addr_i[31:6] == BaseAddr[31:6]);
   assign handshake        = data_req_i && data_gnt_o;
   assign mem_we           = handshake && data_we_i && in_range && (idx != IdxW'(NumWords));
   assign unused_addr_bits = ^data_addr_i[1:0];

   // Response payload as seen at the handshake edge
   always_comb begin
      rd_val = '0;
      rd_err = 1'b0;
      if (!in_range) begin
         rd_err = 1'b1;
      end else if (data_we_i) begin
         rd_err = (idx == IdxW'(NumWords));
      end else if (idx == IdxW'(NumWords)) begin
         rd_val = cycle_cnt;
      end else begin
         rd_val = mem[idx];
      end
   end

   // Free-running cycle counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cycle_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + DataW'(1);
      end
   end

   // Word storage with per-byte write enables
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < NumWords; i++) begin
            mem[i] <= '0;
         end
      end else if (mem_we) begin
         for (int unsigned b = 0; b < NumBytes; b++) begin
            if (data_be_i[b]) begin
               mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
            end
         end
      end
   end

   // Handshake FSM; all bus outputs are registered here
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         resp_rdata    <= '0;
         resp_err      <= 1'b0;
         data_gnt_o    <= 1'b0;
         data_rvalid_o <= 1'b0;
         data_rdata_o  <= '0;
         data_err_o    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               data_gnt_o <= 1'b1;
               if (handshake) begin
                  data_gnt_o <= 1'b0;
                  resp_rdata <= rd_val;
                  resp_err   <= rd_err;
                  if (Latency == 1) begin
                     state         <= RESP;
                     data_rvalid_o <= 1'b1;
                     data_rdata_o  <= rd_val;
                     data_err_o    <= rd_err;
                  end else begin
                     state    <= WAIT;
                     wait_cnt <= WaitW'(Latency - 2);
                  end
               end
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  state         <= RESP;
                  data_rvalid_o <= 1'b1;
                  data_rdata_o  <= resp_rdata;
                  data_err_o    <= resp_err;
               end else begin
                  wait_cnt <= wait_cnt - WaitW'(1);
               end
            end
            RESP: begin
               state         <= IDLE;
               data_gnt_o    <= 1'b1;
               data_rvalid_o <= 1'b0;
               data_rdata_o  <= '0;
               data_err_o    <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ibex_data_resp.sv
// Bench for ibex_data_resp: three instances (Latency 1, 4, 3) checked against
// a word-array model, directed vectors and randomized traffic.
module tb_ibex_data_resp;

   localparam logic [31:0] BASE = 32'h0001_0000;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;

   logic        gnt0, gnt1, gnt2;
   logic        rv0, rv1, rv2;
   logic        err0, err1, err2;
   logic [31:0] rd0, rd1, rd2;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] cyc;
   logic [31:0] mm [3][15];
   int          lat [3] = '{1, 4, 3};

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic        err;
      logic [31:0] rdata;
   } obs_t;

   typedef struct {
      logic        w;
      logic [3:0]  b;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] xrd;
      logic        xerr;
   } vec_t;

   always #5 clk = ~clk;

   // Cycles elapsed since reset released (value during the current cycle)
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= '0;
      else        cyc <= cyc + 32'd1;
   end

   ibex_data_resp #(.BaseAddr(BASE), .Latency(1)) u_l1 (
      .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[0]), .data_gnt_o(gnt0),
      .data_rvalid_o(rv0), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
      .data_wdata_i(wdata), .data_rdata_o(rd0), .data_err_o(err0));

   ibex_data_resp #(.BaseAddr(BASE), .Latency(4)) u_l4 (
      .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[1]), .data_gnt_o(gnt1),
      .data_rvalid_o(rv1), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
      .data_wdata_i(wdata), .data_rdata_o(rd1), .data_err_o(err1));

   ibex_data_resp #(.BaseAddr(BASE), .Latency(3)) u_l3 (
      .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[2]), .data_gnt_o(gnt2),
      .data_rvalid_o(rv2), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
      .data_wdata_i(wdata), .data_rdata_o(rd2), .data_err_o(err2));

   function automatic obs_t obs(int d);
      case (d)
         0:       return '{gnt0, rv0, err0, rd0};
         1:       return '{gnt1, rv1, err1, rd1};
         default: return '{gnt2, rv2, err2, rd2};
      endcase
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_model();
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < 15; i++) mm[d][i] = '0;
   endtask

   // Reference behaviour of one granted access
   task automatic model_step(input int d, input logic w, input logic [3:0] b,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] cnt,
                             output logic [31:0] erd, output logic eerr);
      int          i;
      logic [31:0] m;
      i    = int'(a[5:2]);
      erd  = '0;
      eerr = 1'b0;
      if (a[31:6] != BASE[31:6]) begin
         eerr = 1'b1;
      end else if (w) begin
         if (i == 15) eerr = 1'b1;
         else begin
            m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
            mm[d][i] = (mm[d][i] & ~m) | (wd & m);
         end
      end else begin
         erd = (i == 15) ? cnt : mm[d][i];
      end
   endtask

   // Issue one request (called at a falling edge), check timing, return response
   task automatic access(input int d, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic e,
                         output logic [31:0] erd, output logic eerr,
                         output logic [31:0] gc);
      int   waited = 0;
      obs_t o;
      rd = '0; e = 1'b0; erd = '0; eerr = 1'b0; gc = '0;
      we = w; be = b; addr = a; wdata = wd; req[d] = 1'b1;
      while (obs(d).gnt !== 1'b1 && waited < 32) begin
         @(negedge clk);
         waited++;
      end
      if (obs(d).gnt !== 1'b1) begin
         check("gnt_timeout", 32'(obs(d).gnt), 32'd1);
         req[d] = 1'b0;
         return;
      end
      gc = cyc;
      model_step(d, w, b, a, wd, cyc, erd, eerr);
      @(negedge clk);
      req[d] = 1'b0;
      we = 1'($urandom); be = 4'($urandom); addr = $urandom; wdata = $urandom;
      for (int k = 1; k <= lat[d]; k++) begin
         o = obs(d);
         check("gnt_low_busy", 32'(o.gnt), 32'd0);
         if (k == lat[d]) begin
            check("rvalid_at_latency", 32'(o.rvalid), 32'd1);
            rd = o.rdata;
            e  = o.err;
         end else begin
            check("rvalid_early", 32'(o.rvalid), 32'd0);
            check("rdata_no_rvalid", o.rdata, 32'd0);
         end
         @(negedge clk);
      end
      o = obs(d);
      check("gnt_back", 32'(o.gnt), 32'd1);
      check("rvalid_one_cycle", 32'(o.rvalid), 32'd0);
      check("rdata_idle", o.rdata, 32'd0);
      check("err_idle", 32'(o.err), 32'd0);
   endtask

   task automatic check_reset_outputs(string tag);
      for (int d = 0; d < 3; d++) begin
         check({tag, "_gnt"},    32'(obs(d).gnt),    32'd0);
         check({tag, "_rvalid"}, 32'(obs(d).rvalid), 32'd0);
         check({tag, "_err"},    32'(obs(d).err),    32'd0);
         check({tag, "_rdata"},  obs(d).rdata,       32'd0);
      end
   endtask

   initial begin
      vec_t        tbl [12];
      logic [31:0] rd, erd, gc, a;
      logic        e, eerr;
      int          r;

      tbl[0]  = '{1'b1, 4'hF, BASE + 32'h08, 32'h1234_5678, 32'h0,          1'b0};
      tbl[1]  = '{1'b0, 4'hF, BASE + 32'h08, 32'h0,         32'h1234_5678, 1'b0};
      tbl[2]  = '{1'b1, 4'hF, BASE + 32'h0C, 32'hAABB_CCDD, 32'h0,          1'b0};
      tbl[3]  = '{1'b1, 4'h5, BASE + 32'h0C, 32'h1122_3344, 32'h0,          1'b0};
      tbl[4]  = '{1'b0, 4'hF, BASE + 32'h0C, 32'h0,         32'hAA22_CC44, 1'b0};
      tbl[5]  = '{1'b0, 4'hF, BASE + 32'h40, 32'h0,         32'h0,          1'b1};
      tbl[6]  = '{1'b1, 4'hF, BASE - 32'h04, 32'hDEAD_BEEF, 32'h0,          1'b1};
      tbl[7]  = '{1'b1, 4'h0, BASE + 32'h08, 32'hFFFF_FFFF, 32'h0,          1'b0};
      tbl[8]  = '{1'b0, 4'hF, BASE + 32'h0B, 32'h0,         32'h1234_5678, 1'b0};
      tbl[9]  = '{1'b0, 4'hF, BASE + 32'h0C, 32'h0,         32'hAA22_CC44, 1'b0};
      tbl[10] = '{1'b0, 4'hF, BASE + 32'h00, 32'h0,         32'h0,          1'b0};
      tbl[11] = '{1'b1, 4'hF, BASE + 32'h3C, 32'h0,         32'h0,          1'b1};

      req = '0; we = 1'b0; be = '0; addr = '0; wdata = '0;
      clear_model();
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 3; d++) check("gnt_after_reset", 32'(obs(d).gnt), 32'd1);

      // Directed vectors on the Latency=1 instance
      for (int i = 0; i < 12; i++) begin
         access(0, tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].wd, rd, e, erd, eerr, gc);
         check($sformatf("vec%0d_rdata", i), rd, tbl[i].xrd);
         check($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].xerr));
      end

      // Every word intact after the out-of-range accesses
      for (int i = 0; i < 15; i++) begin
         access(0, 1'b0, 4'hF, BASE + 32'(4 * i), 32'h0, rd, e, erd, eerr, gc);
         check($sformatf("word%0d_intact", i), rd, erd);
      end

      // Cycle counter reads return the grant-cycle count
      for (int i = 0; i < 2; i++) begin
         repeat (i * 5) @(negedge clk);
         access(0, 1'b0, 4'hF, BASE + 32'h3C, 32'h0, rd, e, erd, eerr, gc);
         check("counter_read", rd, gc);
         check("counter_err", 32'(e), 32'd0);
      end

      // Back-to-back on Latency=4 (timing checked inside access)
      for (int i = 0; i < 4; i++) begin
         access(1, 1'b1, 4'hF, BASE + 32'(4 * i), 32'hA5A5_0000 + 32'(i), rd, e, erd, eerr, gc);
         check("l4_wr_err", 32'(e), 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
         access(1, 1'b0, 4'hF, BASE + 32'(4 * i), 32'h0, rd, e, erd, eerr, gc);
         check("l4_rd_data", rd, 32'hA5A5_0000 + 32'(i));
      end

      // Randomized traffic against the model
      for (int d = 0; d < 3; d++) begin
         for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8)       a = BASE + ($urandom & 32'h3F);
            else if (r == 8) a = BASE + 32'h40 + ($urandom & 32'hFFF);
            else             a = BASE - 32'h4 - ($urandom & 32'hFFC);
            access(d, 1'($urandom), 4'($urandom), a, $urandom, rd, e, erd, eerr, gc);
            check($sformatf("rand_d%0d_rdata", d), rd, erd);
            check($sformatf("rand_d%0d_err", d), 32'(e), 32'(eerr));
         end
      end

      // Reset while the Latency=3 instance is waiting
      access(2, 1'b1, 4'hF, BASE, 32'hCAFE_F00D, rd, e, erd, eerr, gc);
      we = 1'b0; be = 4'hF; addr = BASE; req[2] = 1'b1;
      check("l3_pre_gnt", 32'(gnt2), 32'd1);
      @(negedge clk);
      req[2] = 1'b0;
      check("l3_in_wait", 32'(rv2), 32'd0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clear_model();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("no_stale_rvalid", 32'(rv2), 32'd0);
      end
      access(2, 1'b0, 4'hF, BASE, 32'h0, rd, e, erd, eerr, gc);
      check("post_reset_word0", rd, 32'h0);
      check("post_reset_err", 32'(e), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
